// File: rtl/cpu_pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects,
// and the register write-port payload seen at the MEM and WB stages.
package cpu_pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZR = 5'd31;

  typedef enum logic [1:0] {
    S_INIT       = 2'd0,
    S_RUN        = 2'd1,
    S_FLUSH_PEND = 2'd2
  } pipeState_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regWrite;
  } wrPort_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control/status bundle between CPU_control and the hazard controller.
// master = decoder/pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic             stall_ext;
  logic             id_ctrl_vld;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_flags;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic             ex_set_flags;
  logic             ex_br_taken;
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write;
  logic [REG_W-1:0] wb_rd;
  logic             wb_reg_write;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output stall_ext, id_ctrl_vld, id_rn, id_rm, id_use_rn, id_use_rm, id_use_flags,
           ex_rd, ex_reg_write, ex_mem_to_reg, ex_set_flags, ex_br_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_ext, id_ctrl_vld, id_rn, id_rm, id_use_rn, id_use_rm, id_use_flags,
           ex_rd, ex_reg_write, ex_mem_to_reg, ex_set_flags, ex_br_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    output pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_select.sv
// Chooses the ALU operand source for one ID source register; MEM beats WB
// because it carries the newer value, and X31 never forwards.
module fwd_select
  import cpu_pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             srcUsed,
  input  wrPort_t          memWr,
  input  wrPort_t          wbWr,
  output fwd_sel_t         selC
);

  always_comb begin
    selC = FWD_RF;
    if (srcUsed) begin
      if (memWr.regWrite && (memWr.rd != REG_ZR) && (memWr.rd == src)) begin
        selC = FWD_EXMEM;
      end else if (wbWr.regWrite && (wbWr.rd != REG_ZR) && (wbWr.rd == src)) begin
        selC = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: pipeline fill, freeze, load-use/flag
// stalls, taken-branch flushes, operand forwarding and saturating event counters.
module pipeline_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned INIT_CYC = 4,
  parameter int unsigned CNT_W    = 16
)(
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  pipeState_t        state, stateNext;
  logic [INIT_W-1:0] initCnt, initCntNext;
  logic [CNT_W-1:0]  stallCnt, flushCnt;

  logic     loadUse, flagHaz;
  logic     pcWe, ifidWe, ifidFlush, idexBubble;
  logic     stallInc, flushInc;
  fwd_sel_t fwdA, fwdB;
  fwd_sel_t fwdAOut, fwdBOut;
  wrPort_t  memWr, wbWr;

  assign loadUse = bus.ex_reg_write && bus.ex_mem_to_reg && (bus.ex_rd != REG_ZR) &&
                   ((bus.id_use_rn && (bus.ex_rd == bus.id_rn)) ||
                    (bus.id_use_rm && (bus.ex_rd == bus.id_rm)));
  assign flagHaz = bus.id_use_flags && bus.ex_set_flags;

  assign memWr = '{rd: bus.mem_rd, regWrite: bus.mem_reg_write};
  assign wbWr  = '{rd: bus.wb_rd,  regWrite: bus.wb_reg_write};

  fwd_select u_fwdA (
    .src     (bus.id_rn),
    .srcUsed (bus.id_use_rn),
    .memWr   (memWr),
    .wbWr    (wbWr),
    .selC    (fwdA)
  );

  fwd_select u_fwdB (
    .src     (bus.id_rm),
    .srcUsed (bus.id_use_rm),
    .memWr   (memWr),
    .wbWr    (wbWr),
    .selC    (fwdB)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      initCnt  <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      state   <= stateNext;
      initCnt <= initCntNext;
      if (stallInc && (stallCnt != {CNT_W{1'b1}})) stallCnt <= stallCnt + CNT_W'(1);
      if (flushInc && (flushCnt != {CNT_W{1'b1}})) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  // Next state and pipeline-register controls; a branch seen during a freeze is parked.
  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    pcWe        = 1'b0;
    ifidWe      = 1'b0;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    stallInc    = 1'b0;
    flushInc    = 1'b0;
    fwdAOut     = fwdA;
    fwdBOut     = fwdB;

    unique case (state)
      S_INIT: begin
        pcWe       = 1'b1;
        ifidWe     = 1'b1;
        idexBubble = 1'b1;
        if (!bus.stall_ext) begin
          if (initCnt == INIT_W'(INIT_CYC - 1)) begin
            stateNext = S_RUN;
          end else begin
            initCntNext = initCnt + INIT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (bus.stall_ext) begin
          if (bus.ex_br_taken) stateNext = S_FLUSH_PEND;
        end else if (bus.ex_br_taken) begin
          pcWe       = 1'b1;
          ifidWe     = 1'b1;
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
          flushInc   = 1'b1;
        end else if (loadUse || flagHaz) begin
          idexBubble = 1'b1;
          stallInc   = 1'b1;
        end else if (!bus.id_ctrl_vld) begin
          pcWe       = 1'b1;
          ifidWe     = 1'b1;
          idexBubble = 1'b1;
        end else begin
          pcWe   = 1'b1;
          ifidWe = 1'b1;
        end
      end
      S_FLUSH_PEND: begin
        if (!bus.stall_ext) begin
          pcWe       = 1'b1;
          ifidWe     = 1'b1;
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
          flushInc   = 1'b1;
          stateNext  = S_RUN;
        end
      end
      default: stateNext = S_INIT;
    endcase

    // While reset is held the pipeline is parked on NOPs regardless of state.
    if (reset) begin
      pcWe       = 1'b0;
      ifidWe     = 1'b0;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
      fwdAOut    = FWD_RF;
      fwdBOut    = FWD_RF;
    end
  end

  assign bus.pc_we       = pcWe;
  assign bus.ifid_we     = ifidWe;
  assign bus.ifid_flush  = ifidFlush;
  assign bus.idex_bubble = idexBubble;
  assign bus.fwd_a       = fwdAOut;
  assign bus.fwd_b       = fwdBOut;
  assign bus.stall_cnt   = stallCnt;
  assign bus.flush_cnt   = flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle and a
// monitor compares two controllers (16-bit and 2-bit counters) on the falling edge.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    int         tag;
    logic [3:0] ctl;  // {pc_we, ifid_we, ifid_flush, idex_bubble}
    logic [1:0] fa;
    logic [1:0] fb;
    int         sc;
    int         fc;
  } exp_t;

  logic clk;
  logic rst;
  logic stallExt, idCtrlVld, idUseRn, idUseRm, idUseFlags;
  logic exRegWrite, exMemToReg, exSetFlags, exBrTaken, memRegWrite, wbRegWrite;
  logic [4:0] idRn, idRm, exRd, memRd, wbRd;

  exp_t expQ[$];
  exp_t cur;
  int   tagCnt   = 0;
  int   checkCnt = 0;
  int   passCnt  = 0;
  int   monCyc   = 0;
  bit   stimDone = 1'b0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) ifA();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  ifB();

  assign ifA.stall_ext     = stallExt;    assign ifB.stall_ext     = stallExt;
  assign ifA.id_ctrl_vld   = idCtrlVld;   assign ifB.id_ctrl_vld   = idCtrlVld;
  assign ifA.id_rn         = idRn;        assign ifB.id_rn         = idRn;
  assign ifA.id_rm         = idRm;        assign ifB.id_rm         = idRm;
  assign ifA.id_use_rn     = idUseRn;     assign ifB.id_use_rn     = idUseRn;
  assign ifA.id_use_rm     = idUseRm;     assign ifB.id_use_rm     = idUseRm;
  assign ifA.id_use_flags  = idUseFlags;  assign ifB.id_use_flags  = idUseFlags;
  assign ifA.ex_rd         = exRd;        assign ifB.ex_rd         = exRd;
  assign ifA.ex_reg_write  = exRegWrite;  assign ifB.ex_reg_write  = exRegWrite;
  assign ifA.ex_mem_to_reg = exMemToReg;  assign ifB.ex_mem_to_reg = exMemToReg;
  assign ifA.ex_set_flags  = exSetFlags;  assign ifB.ex_set_flags  = exSetFlags;
  assign ifA.ex_br_taken   = exBrTaken;   assign ifB.ex_br_taken   = exBrTaken;
  assign ifA.mem_rd        = memRd;       assign ifB.mem_rd        = memRd;
  assign ifA.mem_reg_write = memRegWrite; assign ifB.mem_reg_write = memRegWrite;
  assign ifA.wb_rd         = wbRd;        assign ifB.wb_rd         = wbRd;
  assign ifA.wb_reg_write  = wbRegWrite;  assign ifB.wb_reg_write  = wbRegWrite;

  pipeline_hazard_ctrl #(.INIT_CYC(4), .CNT_W(16)) dutA (.clk(clk), .reset(rst), .bus(ifA));
  pipeline_hazard_ctrl #(.INIT_CYC(4), .CNT_W(2))  dutB (.clk(clk), .reset(rst), .bus(ifB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    stallExt = 1'b0; idCtrlVld = 1'b1; idUseRn = 1'b0; idUseRm = 1'b0; idUseFlags = 1'b0;
    exRegWrite = 1'b0; exMemToReg = 1'b0; exSetFlags = 1'b0; exBrTaken = 1'b0;
    memRegWrite = 1'b0; wbRegWrite = 1'b0;
    idRn = 5'd0; idRm = 5'd0; exRd = 5'd0; memRd = 5'd0; wbRd = 5'd0;
  endtask

  // EX holds a load to rd and the ID instruction reads rd as Rn.
  task automatic loadUse(input logic [4:0] rd);
    exRd = rd; exRegWrite = 1'b1; exMemToReg = 1'b1;
    idRn = rd; idUseRn = 1'b1;
  endtask

  task automatic expectV(input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                         input int sc, input int fc);
    exp_t e;
    e.tag = tagCnt; e.ctl = ctl; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    tagCnt++;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic checkDut(input int tag, input string nm,
                          input logic [3:0] gCtl, input logic [1:0] gFa, input logic [1:0] gFb,
                          input int gSc, input int gFc,
                          input logic [3:0] wCtl, input logic [1:0] wFa, input logic [1:0] wFb,
                          input int wSc, input int wFc);
    checkCnt++;
    if (gCtl === wCtl && gFa === wFa && gFb === wFb && gSc == wSc && gFc == wFc) begin
      passCnt++;
    end else begin
      $display("FAIL vec%0d %s: got ctl=%b fa=%b fb=%b stall=%0d flush=%0d, want ctl=%b fa=%b fb=%b stall=%0d flush=%0d",
               tag, nm, gCtl, gFa, gFb, gSc, gFc, wCtl, wFa, wFb, wSc, wFc);
    end
  endtask

  // Monitor: pops one expectation per falling edge, owns the counts and the summary.
  initial begin : monitor
    while (!(stimDone && expQ.size() == 0) && monCyc < 2000) begin
      @(negedge clk);
      monCyc++;
      if (expQ.size() > 0) begin
        cur = expQ.pop_front();
        checkDut(cur.tag, "cnt16",
                 {ifA.pc_we, ifA.ifid_we, ifA.ifid_flush, ifA.idex_bubble}, ifA.fwd_a, ifA.fwd_b,
                 int'(ifA.stall_cnt), int'(ifA.flush_cnt),
                 cur.ctl, cur.fa, cur.fb, cur.sc, cur.fc);
        checkDut(cur.tag, "cnt2",
                 {ifB.pc_we, ifB.ifid_we, ifB.ifid_flush, ifB.idex_bubble}, ifB.fwd_a, ifB.fwd_b,
                 int'(ifB.stall_cnt), int'(ifB.flush_cnt),
                 cur.ctl, cur.fa, cur.fb, sat3(cur.sc), sat3(cur.fc));
      end
    end
    if (!(stimDone && expQ.size() == 0)) begin
      checkCnt++;
      $display("FAIL watchdog: got %0d pending expectations after %0d cycles, want 0", expQ.size(), monCyc);
    end
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin : stim
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // Reset held: NOP outputs, forwarding suppressed even with a matching MEM write.
    idRn = 5'd5; idUseRn = 1'b1; memRd = 5'd5; memRegWrite = 1'b1;
    expectV(4'b0011, 2'b00, 2'b00, 0, 0);
    rst = 1'b0;
    repeat (4) begin idle(); expectV(4'b1101, 2'b00, 2'b00, 0, 0); end
    idle(); expectV(4'b1100, 2'b00, 2'b00, 0, 0);
    idle(); idCtrlVld = 1'b0; expectV(4'b1101, 2'b00, 2'b00, 0, 0);
    // LDUR X2 in EX, ADDS X3,X2,X4 in ID: one stall, then X2 comes from MEM/WB.
    idle(); loadUse(5'd2); idRm = 5'd4; idUseRm = 1'b1; expectV(4'b0001, 2'b00, 2'b00, 0, 0);
    idle(); idRn = 5'd2; idUseRn = 1'b1; idRm = 5'd4; idUseRm = 1'b1; wbRd = 5'd2; wbRegWrite = 1'b1;
    expectV(4'b1100, 2'b10, 2'b00, 1, 0);
    idle(); idUseFlags = 1'b1; exSetFlags = 1'b1; expectV(4'b0001, 2'b00, 2'b00, 1, 0);
    idle(); expectV(4'b1100, 2'b00, 2'b00, 2, 0);
    idle(); loadUse(5'd31); expectV(4'b1100, 2'b00, 2'b00, 2, 0);
    // Taken branch beats a simultaneous load-use.
    idle(); loadUse(5'd2); exBrTaken = 1'b1; expectV(4'b1111, 2'b00, 2'b00, 2, 0);
    idle(); expectV(4'b1100, 2'b00, 2'b00, 2, 1);
    // Branch during a 3-cycle freeze: flush lands on the first unfrozen cycle.
    idle(); stallExt = 1'b1; exBrTaken = 1'b1; expectV(4'b0000, 2'b00, 2'b00, 2, 1);
    idle(); stallExt = 1'b1; expectV(4'b0000, 2'b00, 2'b00, 2, 1);
    idle(); stallExt = 1'b1; expectV(4'b0000, 2'b00, 2'b00, 2, 1);
    idle(); loadUse(5'd2); expectV(4'b1111, 2'b00, 2'b00, 2, 1);
    idle(); expectV(4'b1100, 2'b00, 2'b00, 2, 2);
    idle(); stallExt = 1'b1; loadUse(5'd2); expectV(4'b0000, 2'b00, 2'b00, 2, 2);
    // Forwarding selections.
    idle(); memRd = 5'd5; memRegWrite = 1'b1; wbRd = 5'd5; wbRegWrite = 1'b1;
    idRm = 5'd5; idUseRm = 1'b1; idRn = 5'd31; idUseRn = 1'b1;
    expectV(4'b1100, 2'b00, 2'b01, 2, 2);
    idle(); memRd = 5'd31; memRegWrite = 1'b1; wbRd = 5'd31; wbRegWrite = 1'b1; idRn = 5'd31; idUseRn = 1'b1;
    expectV(4'b1100, 2'b00, 2'b00, 2, 2);
    idle(); memRd = 5'd5; memRegWrite = 1'b1; wbRd = 5'd6; wbRegWrite = 1'b1;
    idRn = 5'd6; idUseRn = 1'b1; idRm = 5'd5; idUseRm = 1'b1;
    expectV(4'b1100, 2'b10, 2'b01, 2, 2);
    idle(); memRd = 5'd5; memRegWrite = 1'b1; wbRd = 5'd6; wbRegWrite = 1'b1; idRn = 5'd6; idRm = 5'd5;
    expectV(4'b1100, 2'b00, 2'b00, 2, 2);
    idle(); memRd = 5'd7; wbRd = 5'd7; wbRegWrite = 1'b1; idRn = 5'd7; idUseRn = 1'b1;
    expectV(4'b1100, 2'b10, 2'b00, 2, 2);
    // Five more load-use stalls: the 2-bit counter pins at 3.
    for (int i = 0; i < 5; i++) begin
      idle(); loadUse(5'd3); expectV(4'b0001, 2'b00, 2'b00, 2 + i, 2);
    end
    idle(); expectV(4'b1100, 2'b00, 2'b00, 7, 2);
    // Park a flush behind a freeze, then reset over it.
    idle(); stallExt = 1'b1; exBrTaken = 1'b1; expectV(4'b0000, 2'b00, 2'b00, 7, 2);
    rst = 1'b1;
    idle(); loadUse(5'd2); memRd = 5'd2; memRegWrite = 1'b1; expectV(4'b0011, 2'b00, 2'b00, 0, 0);
    rst = 1'b0;
    idle(); stallExt = 1'b1; expectV(4'b1101, 2'b00, 2'b00, 0, 0);
    repeat (4) begin idle(); expectV(4'b1101, 2'b00, 2'b00, 0, 0); end
    idle(); expectV(4'b1100, 2'b00, 2'b00, 0, 0);
    stimDone = 1'b1;
  end

endmodule
